clock_mode_controller: RTL and testbench

Time-keeping and time-set sequencer for the digital clock. It consumes the 1 Hz carry pulse from the prescaler modulo counter and maintains cascaded HH:MM:SS registers. A MODE/UP button FSM pauses the prescaler and lets the user set hours, minutes and seconds. The block sits between the prescaler counter and the 7-segment display driver, and it drives the prescaler's Enable input.

---
 rtl/clock_pkg.sv | 17 +
 rtl/wrap_inc.sv | 13 +
 rtl/clock_mode_controller.sv | 114 +++++++++++
 tb/tb_clock_mode_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encodings, field limits and widths for the clock sequencer
package clock_pkg;
  localparam int HW = 5;
  localparam int MW = 6;
  localparam int MODE_W = 3;
  localparam logic [HW-1:0] HOUR_MAX = 5'd23;
  localparam logic [MW-1:0] MIN_MAX = 6'd59;
  localparam logic [MW-1:0] SEC_MAX = 6'd59;
  typedef enum logic [MODE_W-1:0] {
    RUN = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } mode_t;
endpackage

// File: rtl/wrap_inc.sv
// wrap_inc: conditional incrementer that wraps to zero past a limit and flags the wrap as a carry
module wrap_inc #(
  parameter int W = 6
) (
  input  logic [W-1:0] val,
  input  logic [W-1:0] lim,
  input  logic         inc,
  output logic [W-1:0] nxt,
  output logic         carry
);
  assign carry = inc && (val == lim);
  assign nxt = !inc ? val : carry ? '0 : val + 1'b1;
endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller: HH:MM:SS keeper with MODE/UP time-set FSM and edit blink; optional alarm via ALARM_EN
import clock_pkg::*;
module clock_mode_controller #(
  parameter int BLINK_HALF = 24_999_999,
  parameter int BW = 32
) (
  input  logic              TICK,
  input  logic              RESET_N,
  input  logic              SEC_PULSE,
  input  logic              BTN_MODE,
  input  logic              BTN_UP,
  output logic              PRESCALE_EN,
  output logic [HW-1:0]     HOUR,
  output logic [MW-1:0]     MIN,
  output logic [MW-1:0]     SEC,
  output logic [MODE_W-1:0] MODE,
`ifdef ALARM_EN
  output logic              BLINK,
  output logic              ALARM
`else
  output logic              BLINK
`endif
);
`ifdef ALARM_EN
  localparam mode_t LAST_MODE = SET_AM;
`else
  localparam mode_t LAST_MODE = SET_S;
`endif
  mode_t state, next;
  logic mode_q, up_q, mode_raw, up_raw, up_e, run_tick;
  logic [HW-1:0] hour_n;
  logic [MW-1:0] min_n, sec_n;
  logic sec_c, min_c, hour_c_unused;
  logic [BW-1:0] cnt;
  assign mode_raw = BTN_MODE & ~mode_q;
  assign up_raw = BTN_UP & ~up_q;
  assign up_e = up_raw & ~mode_raw;
  assign run_tick = (state == RUN) && SEC_PULSE;
  wrap_inc #(.W(MW)) u_sec (.val(SEC), .lim(SEC_MAX), .inc(run_tick), .nxt(sec_n), .carry(sec_c));
  wrap_inc #(.W(MW)) u_min (.val(MIN), .lim(MIN_MAX), .inc(sec_c || (state == SET_M && up_e)), .nxt(min_n), .carry(min_c));
  wrap_inc #(.W(HW)) u_hour (.val(HOUR), .lim(HOUR_MAX), .inc((min_c && run_tick) || (state == SET_H && up_e)), .nxt(hour_n), .carry(hour_c_unused));
  // State register; PRESCALE_EN is a registered decode of the next state
  always_ff @(posedge TICK or negedge RESET_N)
    if (!RESET_N) begin
      state <= RUN;
      PRESCALE_EN <= 1'b1;
    end else begin
      state <= next;
      PRESCALE_EN <= (next == RUN);
    end
  // Next state: each MODE edge advances one step, wrapping back to RUN after the last set mode
  always_comb begin
    next = mode_raw ? ((state == LAST_MODE) ? RUN : mode_t'(state + 3'd1)) : state;
  end
  // Outputs: MODE exposes the raw state encoding
  always_comb begin
    MODE = state;
  end
  // Button history for rising-edge detection
  always_ff @(posedge TICK or negedge RESET_N)
    if (!RESET_N) begin
      mode_q <= 1'b0;
      up_q <= 1'b0;
    end else begin
      mode_q <= BTN_MODE;
      up_q <= BTN_UP;
    end
  // Time fields: cascaded seconds carry in RUN, single-field edits in the set modes
  always_ff @(posedge TICK or negedge RESET_N)
    if (!RESET_N) begin
      HOUR <= '0;
      MIN <= '0;
      SEC <= '0;
    end else begin
      HOUR <= hour_n;
      MIN <= min_n;
      SEC <= (state == SET_S && up_e) ? '0 : sec_n;
    end
  // Blink strobe: free-running half-period toggle while editing, restarted blank-free on every MODE edge
  always_ff @(posedge TICK or negedge RESET_N)
    if (!RESET_N) begin
      cnt <= '0;
      BLINK <= 1'b0;
    end else if (mode_raw || state == RUN) begin
      cnt <= '0;
      BLINK <= 1'b0;
    end else if (cnt == BW'(BLINK_HALF)) begin
      cnt <= '0;
      BLINK <= ~BLINK;
    end else begin
      cnt <= cnt + 1'b1;
    end
`ifdef ALARM_EN
  logic [HW-1:0] al_hour, al_hour_n;
  logic [MW-1:0] al_min, al_min_n;
  logic al_hour_c_unused, al_min_c_unused, inc_q;
  wrap_inc #(.W(HW)) u_al_hour (.val(al_hour), .lim(HOUR_MAX), .inc(state == SET_AH && up_e), .nxt(al_hour_n), .carry(al_hour_c_unused));
  wrap_inc #(.W(MW)) u_al_min (.val(al_min), .lim(MIN_MAX), .inc(state == SET_AM && up_e), .nxt(al_min_n), .carry(al_min_c_unused));
  // Alarm: armed one cycle after a counted second lands on HH:MM:00, dropped by any button or minute change
  always_ff @(posedge TICK or negedge RESET_N)
    if (!RESET_N) begin
      al_hour <= '0;
      al_min <= '0;
      inc_q <= 1'b0;
      ALARM <= 1'b0;
    end else begin
      al_hour <= al_hour_n;
      al_min <= al_min_n;
      inc_q <= run_tick;
      ALARM <= (mode_raw || up_raw || MIN != al_min) ? 1'b0 :
               (state == RUN && inc_q && HOUR == al_hour && SEC == '0) ? 1'b1 : ALARM;
    end
`endif
endmodule

// File: tb/tb_clock_mode_controller.sv
// tb_clock_mode_controller: randomized and directed checks against a seconds-of-day reference model
module tb_clock_mode_controller;
  localparam int BH = 3;
`ifdef ALARM_EN
  localparam int NM = 6;
`else
  localparam int NM = 4;
`endif
  logic TICK = 0, RESET_N = 0, SEC_PULSE = 0, BTN_MODE = 0, BTN_UP = 0;
  logic PRESCALE_EN, BLINK;
  logic [4:0] HOUR;
  logic [5:0] MIN, SEC;
  logic [2:0] MODE;
  int checks = 0, fails = 0;
  int h, mi, s, m, n, pm, pu;
`ifdef ALARM_EN
  logic ALARM;
  int ah, am, alarm, pend;
`endif
  clock_mode_controller #(.BLINK_HALF(BH), .BW(32)) dut (
    .TICK(TICK), .RESET_N(RESET_N), .SEC_PULSE(SEC_PULSE), .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP),
    .PRESCALE_EN(PRESCALE_EN), .HOUR(HOUR), .MIN(MIN), .SEC(SEC), .MODE(MODE),
`ifdef ALARM_EN
    .BLINK(BLINK), .ALARM(ALARM)
`else
    .BLINK(BLINK)
`endif
  );
  always #5 TICK = ~TICK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    h = 0; mi = 0; s = 0; m = 0; n = 0; pm = 0; pu = 0;
`ifdef ALARM_EN
    ah = 0; am = 0; alarm = 0; pend = 0;
`endif
  endtask
  task automatic model_step(input bit bm, input bit bu, input bit sp);
    bit me, ur, ue;
    int t;
    me = bm && pm == 0;
    ur = bu && pu == 0;
    ue = ur && !me;
    pm = bm;
    pu = bu;
`ifdef ALARM_EN
    if (me || ur || mi != am) alarm = 0;
    else if (pend != 0 && m == 0 && h == ah && s == 0) alarm = 1;
    pend = (m == 0 && sp) ? 1 : 0;
`endif
    if (m == 0 && sp) begin
      t = (h * 3600 + mi * 60 + s + 1) % 86400;
      h = t / 3600;
      mi = (t / 60) % 60;
      s = t % 60;
    end else if (ue) begin
      if (m == 1) h = (h + 1) % 24;
      if (m == 2) mi = (mi + 1) % 60;
      if (m == 3) s = 0;
`ifdef ALARM_EN
      if (m == 4) ah = (ah + 1) % 24;
      if (m == 5) am = (am + 1) % 60;
`endif
    end
    n = (me || m == 0) ? 0 : n + 1;
    if (me) m = (m + 1) % NM;
  endtask
  task automatic check_all(input string tag);
    check({tag, ".hour"}, 32'(HOUR), h);
    check({tag, ".min"}, 32'(MIN), mi);
    check({tag, ".sec"}, 32'(SEC), s);
    check({tag, ".mode"}, 32'(MODE), m);
    check({tag, ".pen"}, 32'(PRESCALE_EN), (m == 0) ? 1 : 0);
    check({tag, ".blink"}, 32'(BLINK), (m != 0 && ((n / (BH + 1)) % 2) == 1) ? 1 : 0);
`ifdef ALARM_EN
    check({tag, ".alarm"}, 32'(ALARM), alarm);
`endif
  endtask
  task automatic step(input bit bm, input bit bu, input bit sp, input string tag);
    @(negedge TICK);
    BTN_MODE = bm;
    BTN_UP = bu;
    SEC_PULSE = sp;
    @(posedge TICK);
    model_step(bm, bu, sp);
    #1 check_all(tag);
  endtask
  task automatic press_mode(input string tag);
    step(1, 0, 0, tag);
    step(0, 0, 0, tag);
  endtask
  task automatic press_up(input string tag);
    step(0, 1, 0, tag);
    step(0, 0, 0, tag);
  endtask
  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge TICK);
    RESET_N = 1;
    for (int i = 0; i < 61; i++) begin
      step(0, 0, 1, "run61");
      step(0, 0, 0, "run61");
    end
    check("run61.min", 32'(MIN), 1);
    check("run61.sec", 32'(SEC), 1);
    press_mode("pre.h");
    while (h != 23) press_up("pre.h");
    press_mode("pre.m");
    while (mi != 59) press_up("pre.m");
    press_mode("pre.s");
    press_up("pre.s");
    press_mode("pre.run");
    for (int i = 0; i < 59; i++) step(0, 0, 1, "pre.run");
    check("pre.hour", 32'(HOUR), 23);
    check("pre.sec", 32'(SEC), 59);
    step(0, 0, 1, "wrap");
    check("wrap.hour", 32'(HOUR), 0);
    check("wrap.min", 32'(MIN), 0);
    check("wrap.sec", 32'(SEC), 0);
    for (int i = 0; i < 42; i++) step(0, 0, 1, "to42");
    press_mode("seth");
    for (int i = 0; i < 25; i++) press_up("seth");
    check("seth.hour", 32'(HOUR), 1);
    check("seth.pen", 32'(PRESCALE_EN), 0);
    step(0, 0, 1, "seth.pulse");
    check("seth.pulse.sec", 32'(SEC), 42);
    press_mode("setm");
    for (int i = 0; i < 59; i++) press_up("setm");
    press_up("setm.wrap");
    check("setm.min", 32'(MIN), 0);
    check("setm.hour", 32'(HOUR), 1);
    press_mode("sets");
    press_up("sets");
    check("sets.sec", 32'(SEC), 0);
    while (m != 0) press_mode("back");
    step(1, 0, 0, "blink.enter");
    check("blink.enter", 32'(BLINK), 0);
    repeat (4) step(0, 0, 0, "blink.run");
    check("blink.on", 32'(BLINK), 1);
    repeat (4) step(0, 0, 0, "blink.run");
    check("blink.off", 32'(BLINK), 0);
    repeat (4) step(0, 0, 0, "blink.run");
    step(1, 0, 0, "blink.mode");
    check("blink.mode", 32'(BLINK), 0);
    check("blink.mode.state", 32'(MODE), 2);
    step(0, 0, 0, "simul");
    press_mode("simul");
    step(0, 0, 0, "simul");
    while (m != 1) press_mode("simul");
    step(1, 1, 0, "simul.both");
    check("simul.mode", 32'(MODE), 2);
    check("simul.hour", 32'(HOUR), 1);
    step(0, 0, 0, "simul");
    while (m != 0) press_mode("simul.back");
`ifdef ALARM_EN
    press_mode("al.h");
    while (h != 0) press_up("al.h");
    press_mode("al.m");
    while (mi != 0) press_up("al.m");
    press_mode("al.s");
    press_up("al.s");
    press_mode("al.ah");
    while (ah != 0) press_up("al.ah");
    press_mode("al.am");
    while (am != 1) press_up("al.am");
    press_mode("al.run");
    for (int i = 0; i < 59; i++) step(0, 0, 1, "al.run");
    step(0, 0, 1, "al.hit");
    step(0, 0, 0, "al.hit");
    check("al.on", 32'(ALARM), 1);
    step(0, 1, 0, "al.clear");
    check("al.clear", 32'(ALARM), 0);
    step(0, 0, 0, "al.clear");
`endif
    for (int i = 0; i < 3000; i++)
      step(($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0, "rand");
    while (m != 0) press_mode("rst.norm");
    press_mode("rst.set");
    press_up("rst.set");
    @(negedge TICK);
    #2 RESET_N = 0;
    model_reset();
    #1 check_all("rst.mid");
    check("rst.mode", 32'(MODE), 0);
    check("rst.pen", 32'(PRESCALE_EN), 1);
    @(negedge TICK);
    RESET_N = 1;
    step(0, 0, 1, "rst.after");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
